// File: rtl/axi4_lite_slave_regs_if.sv
// AXI4-Lite bus bundle between a master and axi4_lite_slave_regs.
// Signal names carry the slave's view (_in driven by master, _out driven by slave).
//   slave modport : receives AW/W/AR/B-ready/R-ready, drives readies and B/R responses
//   master modport: the mirror image
interface axi4_lite_slave_regs_if #(
  parameter int unsigned ADDR_WIDTH = 32
) ();
  logic [ADDR_WIDTH-1:0] awaddr_in;
  logic [2:0]            awprot_in;
  logic                  awvalid_in;
  logic                  awready_out;
  logic [31:0]           wdata_in;
  logic [3:0]            wstrb_in;
  logic                  wvalid_in;
  logic                  wready_out;
  logic [1:0]            bresp_out;
  logic                  bvalid_out;
  logic                  bready_in;
  logic [ADDR_WIDTH-1:0] araddr_in;
  logic [2:0]            arprot_in;
  logic                  arvalid_in;
  logic                  arready_out;
  logic [31:0]           rdata_out;
  logic [1:0]            rresp_out;
  logic                  rvalid_out;
  logic                  rready_in;

  modport slave (
    input  awaddr_in, awprot_in, awvalid_in, wdata_in, wstrb_in, wvalid_in, bready_in,
    input  araddr_in, arprot_in, arvalid_in, rready_in,
    output awready_out, wready_out, bresp_out, bvalid_out,
    output arready_out, rdata_out, rresp_out, rvalid_out
  );

  modport master (
    output awaddr_in, awprot_in, awvalid_in, wdata_in, wstrb_in, wvalid_in, bready_in,
    output araddr_in, arprot_in, arvalid_in, rready_in,
    input  awready_out, wready_out, bresp_out, bvalid_out,
    input  arready_out, rdata_out, rresp_out, rvalid_out
  );
endinterface

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite slave register bank: NUM_REGS 32-bit registers with byte strobes.
// Ports:
//   aclk     - clock, rising edge
//   areset   - synchronous active-high reset
//   s_axi    - AXI4-Lite slave modport (AW, W, B, AR, R channels)
//   regs_out - all registers flattened, register i at [32*i+31:32*i]
// Out-of-range word index (addr[ADDR_WIDTH-1:2] >= NUM_REGS) answers SLVERR.
module axi4_lite_slave_regs #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 8
) (
  input  logic                     aclk,
  input  logic                     areset,
  axi4_lite_slave_regs_if.slave    s_axi,
  output logic [32*NUM_REGS-1:0]   regs_out
);

  localparam int unsigned IdxW = ADDR_WIDTH - 2;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  logic [NUM_REGS-1:0][31:0] regs_q, regs_d;

  logic                  aw_full_q, aw_full_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic                  w_full_q, w_full_d;
  logic [31:0]           w_data_q, w_data_d;
  logic [3:0]            w_strb_q, w_strb_d;

  logic       bvalid_q, bvalid_d;
  logic [1:0] bresp_q, bresp_d;
  logic       rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0] rresp_q, rresp_d;

  logic aw_hs, w_hs, ar_hs, commit;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           wr_data;
  logic [3:0]            wr_strb;
  logic [IdxW-1:0]       wr_idx, rd_idx;
  logic                  wr_in_range, rd_in_range;
  logic [31:0]           rd_word;

  // Readies depend only on flops so they never combinationally loop with valids.
  assign s_axi.awready_out = !aw_full_q && !bvalid_q;
  assign s_axi.wready_out  = !w_full_q && !bvalid_q;
  assign s_axi.arready_out = !rvalid_q;

  assign s_axi.bvalid_out = bvalid_q;
  assign s_axi.bresp_out  = bresp_q;
  assign s_axi.rvalid_out = rvalid_q;
  assign s_axi.rdata_out  = rdata_q;
  assign s_axi.rresp_out  = rresp_q;

  assign regs_out = regs_q;

  assign aw_hs = s_axi.awvalid_in && s_axi.awready_out;
  assign w_hs  = s_axi.wvalid_in && s_axi.wready_out;
  assign ar_hs = s_axi.arvalid_in && s_axi.arready_out;

  // Commit as soon as both halves exist, whether buffered or arriving now.
  assign commit = (aw_full_q || aw_hs) && (w_full_q || w_hs);

  assign wr_addr = aw_full_q ? aw_addr_q : s_axi.awaddr_in;
  assign wr_data = w_full_q ? w_data_q : s_axi.wdata_in;
  assign wr_strb = w_full_q ? w_strb_q : s_axi.wstrb_in;

  assign wr_idx      = wr_addr[ADDR_WIDTH-1:2];
  assign rd_idx      = s_axi.araddr_in[ADDR_WIDTH-1:2];
  assign wr_in_range = wr_idx < IdxW'(NUM_REGS);
  assign rd_in_range = rd_idx < IdxW'(NUM_REGS);

  logic unused_ok;
  assign unused_ok = ^{s_axi.awprot_in, s_axi.arprot_in, wr_addr[1:0], s_axi.araddr_in[1:0]};

  always_comb begin
    regs_d  = regs_q;
    rd_word = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (commit && wr_in_range && (wr_idx == IdxW'(i))) begin
        for (int b = 0; b < 4; b++) begin
          if (wr_strb[b]) begin
            regs_d[i][8*b +: 8] = wr_data[8*b +: 8];
          end
        end
      end
      // Reads sample regs_q, so a same-edge write is not visible yet.
      if (rd_idx == IdxW'(i)) begin
        rd_word = regs_q[i];
      end
    end
  end

  always_comb begin
    aw_full_d = aw_full_q;
    aw_addr_d = aw_addr_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;

    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_addr_d = s_axi.awaddr_in;
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      w_data_d = s_axi.wdata_in;
      w_strb_d = s_axi.wstrb_in;
    end

    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_in_range ? RespOkay : RespSlverr;
    end else if (bvalid_q && s_axi.bready_in) begin
      bvalid_d = 1'b0;
      bresp_d  = RespOkay;
    end

    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_in_range ? rd_word : 32'h0;
      rresp_d  = rd_in_range ? RespOkay : RespSlverr;
    end else if (rvalid_q && s_axi.rready_in) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      regs_q    <= '0;
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      regs_q    <= regs_d;
      aw_full_q <= aw_full_d;
      aw_addr_q <= aw_addr_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Bench for axi4_lite_slave_regs: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against a transaction-level model.
module tb_axi4_lite_slave_regs;
  localparam int unsigned AW = 32;
  localparam int unsigned NR = 8;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  logic [32*NR-1:0] regs_out;

  always #5 aclk = ~aclk;

  axi4_lite_slave_regs_if #(.ADDR_WIDTH(AW)) bus ();

  axi4_lite_slave_regs #(
    .ADDR_WIDTH(AW),
    .NUM_REGS  (NR)
  ) dut (
    .aclk    (aclk),
    .areset  (areset),
    .s_axi   (bus),
    .regs_out(regs_out)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  logic [31:0]   m_mem [NR];
  logic [AW-1:0] m_awq [$];
  logic [31:0]   m_wdq [$];
  logic [3:0]    m_wsq [$];
  bit            m_bvalid;
  logic [1:0]    m_bresp;
  bit            m_rvalid;
  logic [31:0]   m_rdata;
  logic [1:0]    m_rresp;

  function automatic bit m_awready();
    return (m_awq.size() == 0) && !m_bvalid;
  endfunction

  function automatic bit m_wready();
    return (m_wdq.size() == 0) && !m_bvalid;
  endfunction

  always @(posedge aclk) begin : model
    bit aw_hs, w_hs, ar_hs;
    longint idx;
    logic [AW-1:0] a;
    logic [31:0] d;
    logic [3:0] s;
    if (areset) begin
      for (int i = 0; i < int'(NR); i++) m_mem[i] = 32'h0;
      m_awq.delete();
      m_wdq.delete();
      m_wsq.delete();
      m_bvalid = 0;
      m_bresp  = 2'b00;
      m_rvalid = 0;
      m_rdata  = 32'h0;
      m_rresp  = 2'b00;
    end else begin
      aw_hs = bus.awvalid_in && m_awready();
      w_hs  = bus.wvalid_in && m_wready();
      ar_hs = bus.arvalid_in && !m_rvalid;
      if (m_bvalid && bus.bready_in) m_bvalid = 0;
      if (m_rvalid && bus.rready_in) m_rvalid = 0;
      if (ar_hs) begin
        idx = longint'(bus.araddr_in >> 2);
        m_rvalid = 1;
        if (idx < longint'(NR)) begin
          m_rdata = m_mem[idx];
          m_rresp = 2'b00;
        end else begin
          m_rdata = 32'h0;
          m_rresp = 2'b10;
        end
      end
      if (aw_hs) m_awq.push_back(bus.awaddr_in);
      if (w_hs) begin
        m_wdq.push_back(bus.wdata_in);
        m_wsq.push_back(bus.wstrb_in);
      end
      if (m_awq.size() > 0 && m_wdq.size() > 0) begin
        a = m_awq.pop_front();
        d = m_wdq.pop_front();
        s = m_wsq.pop_front();
        idx = longint'(a >> 2);
        if (idx < longint'(NR)) begin
          for (int b = 0; b < 4; b++) if (s[b]) m_mem[idx][8*b +: 8] = d[8*b +: 8];
          m_bresp = 2'b00;
        end else begin
          m_bresp = 2'b10;
        end
        m_bvalid = 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge aclk) begin
    check("awready", 32'(bus.awready_out), 32'(m_awready()));
    check("wready", 32'(bus.wready_out), 32'(m_wready()));
    check("arready", 32'(bus.arready_out), 32'(!m_rvalid));
    check("bvalid", 32'(bus.bvalid_out), 32'(m_bvalid));
    check("rvalid", 32'(bus.rvalid_out), 32'(m_rvalid));
    if (m_bvalid) check("bresp", 32'(bus.bresp_out), 32'(m_bresp));
    if (m_rvalid) begin
      check("rdata", bus.rdata_out, m_rdata);
      check("rresp", 32'(bus.rresp_out), 32'(m_rresp));
    end
    for (int i = 0; i < int'(NR); i++) begin
      check($sformatf("reg%0d", i), regs_out[32*i +: 32], m_mem[i]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle();
    bus.awaddr_in  = '0;
    bus.awprot_in  = '0;
    bus.awvalid_in = 1'b0;
    bus.wdata_in   = '0;
    bus.wstrb_in   = '0;
    bus.wvalid_in  = 1'b0;
    bus.bready_in  = 1'b1;
    bus.araddr_in  = '0;
    bus.arprot_in  = '0;
    bus.arvalid_in = 1'b0;
    bus.rready_in  = 1'b1;
  endtask

  task automatic set_aw(input logic [AW-1:0] a);
    bus.awaddr_in  = a;
    bus.awvalid_in = 1'b1;
  endtask

  task automatic set_w(input logic [31:0] d, input logic [3:0] s);
    bus.wdata_in  = d;
    bus.wstrb_in  = s;
    bus.wvalid_in = 1'b1;
  endtask

  function automatic logic [31:0] reg_at(input int i);
    return regs_out[32*i +: 32];
  endfunction

  initial begin
    idle();
    areset = 1'b1;
    step();
    step();
    areset = 1'b0;

    // Reset mid-write: AW buffered, W pending
    set_aw(32'd8);
    step();
    bus.awvalid_in = 1'b0;
    areset = 1'b1;
    step();
    step();
    check("t1_bvalid", 32'(bus.bvalid_out), 32'h0);
    check("t1_rvalid", 32'(bus.rvalid_out), 32'h0);
    check("t1_rdata", bus.rdata_out, 32'h0);
    check("t1_bresp", 32'(bus.bresp_out), 32'h0);
    check("t1_rresp", 32'(bus.rresp_out), 32'h0);
    for (int i = 0; i < int'(NR); i++) check("t1_regs_zero", reg_at(i), 32'h0);
    areset = 1'b0;
    // W alone must not pair with the aborted AW
    set_w(32'hCAFEBABE, 4'hF);
    step();
    bus.wvalid_in = 1'b0;
    check("t1_no_stale_commit", 32'(bus.bvalid_out), 32'h0);
    set_aw(32'd8);
    step();
    bus.awvalid_in = 1'b0;
    check("t1_bvalid_after", 32'(bus.bvalid_out), 32'h1);
    check("t1_reg2", reg_at(2), 32'hCAFEBABE);
    step();

    // Strobed write, AW/W same cycle
    set_aw(32'd16);
    set_w(32'hF0B4A596, 4'b1011);
    step();
    idle();
    check("t2_bvalid", 32'(bus.bvalid_out), 32'h1);
    check("t2_bresp", 32'(bus.bresp_out), 32'h0);
    check("t2_reg4", reg_at(4), 32'hF000A596);
    step();
    check("t2_bvalid_pulse", 32'(bus.bvalid_out), 32'h0);

    // W three cycles ahead of AW
    set_w(32'h12345678, 4'hF);
    step();
    check("t3_wready_held", 32'(bus.wready_out), 32'h0);
    step();
    step();
    check("t3_no_commit_yet", reg_at(1), 32'h0);
    set_aw(32'd4);
    step();
    idle();
    check("t3_bvalid", 32'(bus.bvalid_out), 32'h1);
    check("t3_reg1", reg_at(1), 32'h12345678);
    step();

    // Out-of-range write and read
    set_aw(32'd32);
    set_w(32'hFFFFFFFF, 4'hF);
    step();
    idle();
    check("t4_bresp", 32'(bus.bresp_out), 32'h2);
    check("t4_reg0", reg_at(0), 32'h0);
    step();
    bus.araddr_in  = 32'd40;
    bus.arvalid_in = 1'b1;
    step();
    bus.arvalid_in = 1'b0;
    check("t4_rvalid", 32'(bus.rvalid_out), 32'h1);
    check("t4_rdata", bus.rdata_out, 32'h0);
    check("t4_rresp", 32'(bus.rresp_out), 32'h2);
    step();

    // B backpressure
    bus.bready_in = 1'b0;
    set_aw(32'd0);
    set_w(32'h11111111, 4'hF);
    step();
    set_aw(32'd12);
    set_w(32'h22222222, 4'hF);
    for (int k = 0; k < 5; k++) begin
      step();
      check("t5_awready", 32'(bus.awready_out), 32'h0);
      check("t5_wready", 32'(bus.wready_out), 32'h0);
      check("t5_bvalid", 32'(bus.bvalid_out), 32'h1);
      check("t5_bresp", 32'(bus.bresp_out), 32'h0);
    end
    bus.bready_in = 1'b1;
    step();
    check("t5_reg3_wait", reg_at(3), 32'h0);
    step();
    idle();
    check("t5_reg0", reg_at(0), 32'h11111111);
    check("t5_reg3", reg_at(3), 32'h22222222);
    step();

    // Read/write collision on reg4, then R backpressure
    bus.rready_in  = 1'b0;
    bus.araddr_in  = 32'd16;
    bus.arvalid_in = 1'b1;
    set_aw(32'd16);
    set_w(32'hAABBCCDD, 4'hF);
    step();
    bus.arvalid_in = 1'b0;
    bus.awvalid_in = 1'b0;
    bus.wvalid_in  = 1'b0;
    check("t6_rdata_old", bus.rdata_out, 32'hF000A596);
    check("t6_reg4_new", reg_at(4), 32'hAABBCCDD);
    for (int k = 0; k < 3; k++) begin
      step();
      check("t6_arready", 32'(bus.arready_out), 32'h0);
      check("t6_rvalid", 32'(bus.rvalid_out), 32'h1);
      check("t6_rdata_hold", bus.rdata_out, 32'hF000A596);
    end
    bus.rready_in = 1'b1;
    step();
    check("t6_rvalid_clr", 32'(bus.rvalid_out), 32'h0);
    bus.arvalid_in = 1'b1;
    step();
    bus.arvalid_in = 1'b0;
    check("t6_rdata_new", bus.rdata_out, 32'hAABBCCDD);
    step();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      areset         = ($urandom_range(0, 299) == 0);
      bus.awvalid_in = ($urandom_range(0, 1) == 1);
      bus.awaddr_in  = AW'($urandom_range(0, 4 * NR + 15));
      bus.awprot_in  = 3'($urandom);
      bus.wvalid_in  = ($urandom_range(0, 1) == 1);
      bus.wdata_in   = $urandom;
      bus.wstrb_in   = 4'($urandom);
      bus.bready_in  = ($urandom_range(0, 9) < 7);
      bus.arvalid_in = ($urandom_range(0, 1) == 1);
      bus.araddr_in  = AW'($urandom_range(0, 4 * NR + 15));
      bus.arprot_in  = 3'($urandom);
      bus.rready_in  = ($urandom_range(0, 9) < 7);
      step();
    end
    areset = 1'b0;
    idle();
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
